// File: rtl/pc_regs.sv
// 6502 program counter: PCL/PCH registers with loads from ADL/ADH/DL, a 16-bit increment and PC drivers onto DB/ADL/ADH.
// Latency: loads and increments appear on PC one PHI0 edge after the strobes are sampled; bus drivers are combinational.
// Backpressure: n_ready=1 freezes PC and the pending carry, while ctl_err and the bus drivers keep updating.
module pc_regs #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned CARRY_DELAY = 0
) (
  input  logic       PHI0,
  input  logic       n_RES,
  input  logic       n_ready,
  input  logic       n_1PC,
  input  logic       PCL_PCL,
  input  logic       ADL_PCL,
  input  logic       n_ADL_PCL,
  input  logic       PCH_PCH,
  input  logic       n_PCH_PCH,
  input  logic       ADH_PCH,
  input  logic       DL_PCH,
  input  logic       PC_DB,
  input  logic       PCL_DB,
  input  logic       PCH_DB,
  input  logic       PCL_ADL,
  input  logic       PCH_ADH,
  input  logic [7:0] ADL,
  input  logic [7:0] ADH,
  input  logic [7:0] DL,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic [7:0] ADL_out,
  output logic       ADL_oe,
  output logic [7:0] ADH_out,
  output logic       ADH_oe,
  output logic [15:0] PC,
  output logic       ctl_err
);

  typedef struct packed {
    logic [7:0] pch;
    logic [7:0] pcl;
  } pc_t;

  pc_t        pc_q;
  pc_t        pc_d;
  logic       cy_q;
  logic       cy_d;
  logic       err_q;
  logic       err_d;
  logic [7:0] src_l;
  logic [7:0] src_h;
  logic [8:0] sum_l;
  logic       h_load;
  logic       h_multi;

  always_comb begin
    src_l  = ADL_PCL ? ADL : pc_q.pcl;
    src_h  = DL_PCH ? DL : (ADH_PCH ? ADH : pc_q.pch);
    h_load = DL_PCH | ADH_PCH;
    sum_l  = {1'b0, src_l} + {8'd0, ~n_1PC};
    pc_d.pcl = sum_l[7:0];
    if (CARRY_DELAY == 0) begin
      pc_d.pch = src_h + {7'd0, sum_l[8]};
      cy_d     = 1'b0;
    end else begin
      // A fresh PCH load supersedes any carry still waiting from the last PCL wrap.
      pc_d.pch = h_load ? src_h : (src_h + {7'd0, cy_q});
      cy_d     = sum_l[8];
    end
  end

  always_comb begin
    h_multi = (DL_PCH & ADH_PCH) | (DL_PCH & PCH_PCH) | (ADH_PCH & PCH_PCH);
    err_d   = (ADL_PCL == n_ADL_PCL)
            | (PCH_PCH == n_PCH_PCH)
            | (ADL_PCL & PCL_PCL)
            | h_multi
            | (PC_DB & PCL_DB & PCH_DB);
  end

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      pc_q  <= RESET_PC;
      cy_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (!n_ready) begin
        pc_q <= pc_d;
        cy_q <= cy_d;
      end
    end
  end

  always_comb begin
    PC      = pc_q;
    ctl_err = err_q;
    DB_oe   = n_RES & PC_DB & (PCL_DB | PCH_DB);
    DB_out  = PCL_DB ? pc_q.pcl : pc_q.pch;
    ADL_oe  = n_RES & PCL_ADL;
    ADL_out = pc_q.pcl;
    ADH_oe  = n_RES & PCH_ADH;
    ADH_out = pc_q.pch;
  end

endmodule

// File: tb/tb_pc_regs.sv
// Bench for pc_regs: one instance per carry mode, shared stimulus, scoreboard against a behavioural PC model.
module tb_pc_regs;

  logic PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  logic n_RES, n_ready, n_1PC, PCL_PCL, ADL_PCL, n_ADL_PCL, PCH_PCH, n_PCH_PCH;
  logic ADH_PCH, DL_PCH, PC_DB, PCL_DB, PCH_DB, PCL_ADL, PCH_ADH;
  logic [7:0] ADL, ADH, DL;

  logic [7:0]  db0, adl0, adh0, db1, adl1, adh1;
  logic        db_oe0, adl_oe0, adh_oe0, err0, db_oe1, adl_oe1, adh_oe1, err1;
  logic [15:0] pc0, pc1;

  pc_regs #(.RESET_PC(16'h0000), .CARRY_DELAY(0)) u_cd0 (
    .PHI0(PHI0), .n_RES(n_RES), .n_ready(n_ready), .n_1PC(n_1PC),
    .PCL_PCL(PCL_PCL), .ADL_PCL(ADL_PCL), .n_ADL_PCL(n_ADL_PCL),
    .PCH_PCH(PCH_PCH), .n_PCH_PCH(n_PCH_PCH), .ADH_PCH(ADH_PCH), .DL_PCH(DL_PCH),
    .PC_DB(PC_DB), .PCL_DB(PCL_DB), .PCH_DB(PCH_DB), .PCL_ADL(PCL_ADL), .PCH_ADH(PCH_ADH),
    .ADL(ADL), .ADH(ADH), .DL(DL),
    .DB_out(db0), .DB_oe(db_oe0), .ADL_out(adl0), .ADL_oe(adl_oe0),
    .ADH_out(adh0), .ADH_oe(adh_oe0), .PC(pc0), .ctl_err(err0)
  );

  pc_regs #(.RESET_PC(16'h0000), .CARRY_DELAY(1)) u_cd1 (
    .PHI0(PHI0), .n_RES(n_RES), .n_ready(n_ready), .n_1PC(n_1PC),
    .PCL_PCL(PCL_PCL), .ADL_PCL(ADL_PCL), .n_ADL_PCL(n_ADL_PCL),
    .PCH_PCH(PCH_PCH), .n_PCH_PCH(n_PCH_PCH), .ADH_PCH(ADH_PCH), .DL_PCH(DL_PCH),
    .PC_DB(PC_DB), .PCL_DB(PCL_DB), .PCH_DB(PCH_DB), .PCL_ADL(PCL_ADL), .PCH_ADH(PCH_ADH),
    .ADL(ADL), .ADH(ADH), .DL(DL),
    .DB_out(db1), .DB_oe(db_oe1), .ADL_out(adl1), .ADL_oe(adl_oe1),
    .ADH_out(adh1), .ADH_oe(adh_oe1), .PC(pc1), .ctl_err(err1)
  );

  typedef struct packed {
    logic n_ready, n_1pc, pcl_pcl, adl_pcl, n_adl_pcl, pch_pch, n_pch_pch;
    logic adh_pch, dl_pch, pc_db, pcl_db, pch_db, pcl_adl, pch_adh;
  } strb_t;

  typedef struct {
    logic [15:0] pc0, pc1;
    logic        err, db_oe, adl_oe, adh_oe;
    logic [7:0]  db0, db1;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_pc0, m_pc1;
  int          m_cy1;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic strb_t base();
    strb_t s = '0;
    s.pcl_pcl = 1'b1; s.n_adl_pcl = 1'b1; s.pch_pch = 1'b1; s.n_1pc = 1'b1;
    return s;
  endfunction

  function automatic strb_t inc();
    strb_t s = base();
    s.n_1pc = 1'b0;
    return s;
  endfunction

  function automatic strb_t ld();
    strb_t s = base();
    s.pcl_pcl = 1'b0; s.adl_pcl = 1'b1; s.n_adl_pcl = 1'b0;
    s.pch_pch = 1'b0; s.n_pch_pch = 1'b1; s.adh_pch = 1'b1;
    return s;
  endfunction

  // Drives one cycle of strobes and queues what both instances should show after the next edge.
  task automatic step(input strb_t s, input logic [7:0] adl_v, adh_v, dl_v, input bit rst);
    exp_t e;
    int   incv, lo, hi, nh;
    logic [7:0] sl0, sh0, sl1, sh1;
    @(negedge PHI0);
    n_RES = ~rst; n_ready = s.n_ready; n_1PC = s.n_1pc;
    PCL_PCL = s.pcl_pcl; ADL_PCL = s.adl_pcl; n_ADL_PCL = s.n_adl_pcl;
    PCH_PCH = s.pch_pch; n_PCH_PCH = s.n_pch_pch; ADH_PCH = s.adh_pch; DL_PCH = s.dl_pch;
    PC_DB = s.pc_db; PCL_DB = s.pcl_db; PCH_DB = s.pch_db; PCL_ADL = s.pcl_adl; PCH_ADH = s.pch_adh;
    ADL = adl_v; ADH = adh_v; DL = dl_v;
    if (rst) begin
      m_pc0 = 16'h0000; m_pc1 = 16'h0000; m_cy1 = 0; e.err = 1'b0;
    end else begin
      nh = int'(s.dl_pch) + int'(s.adh_pch) + int'(s.pch_pch);
      e.err = (s.adl_pcl == s.n_adl_pcl) || (s.pch_pch == s.n_pch_pch) ||
              (s.adl_pcl && s.pcl_pcl) || (nh > 1) || (s.pc_db && s.pcl_db && s.pch_db);
      if (!s.n_ready) begin
        incv = s.n_1pc ? 0 : 1;
        sl0 = s.adl_pcl ? adl_v : m_pc0[7:0];
        sh0 = s.dl_pch ? dl_v : (s.adh_pch ? adh_v : m_pc0[15:8]);
        m_pc0 = {sh0, sl0} + 16'(incv);
        sl1 = s.adl_pcl ? adl_v : m_pc1[7:0];
        sh1 = s.dl_pch ? dl_v : (s.adh_pch ? adh_v : m_pc1[15:8]);
        lo = int'(sl1) + incv;
        hi = (s.dl_pch || s.adh_pch) ? int'(sh1) : int'(sh1) + m_cy1;
        m_cy1 = lo / 256;
        m_pc1 = 16'(((hi % 256) * 256) + (lo % 256));
      end
    end
    e.pc0    = m_pc0;
    e.pc1    = m_pc1;
    e.db_oe  = !rst && s.pc_db && (s.pcl_db || s.pch_db);
    e.adl_oe = !rst && s.pcl_adl;
    e.adh_oe = !rst && s.pch_adh;
    e.db0    = s.pcl_db ? m_pc0[7:0] : m_pc0[15:8];
    e.db1    = s.pcl_db ? m_pc1[7:0] : m_pc1[15:8];
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge PHI0);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_cd0", pc0, e.pc0);
        chk("pc_cd1", pc1, e.pc1);
        chk("err_cd0", 16'(err0), 16'(e.err));
        chk("err_cd1", 16'(err1), 16'(e.err));
        chk("db_oe_cd0", 16'(db_oe0), 16'(e.db_oe));
        chk("db_oe_cd1", 16'(db_oe1), 16'(e.db_oe));
        chk("db_out_cd0", 16'(db0), 16'(e.db0));
        chk("db_out_cd1", 16'(db1), 16'(e.db1));
        chk("adl_oe", 16'(adl_oe0), 16'(e.adl_oe));
        chk("adl_out_cd0", 16'(adl0), 16'(e.pc0[7:0]));
        chk("adl_out_cd1", 16'(adl1), 16'(e.pc1[7:0]));
        chk("adh_oe", 16'(adh_oe1), 16'(e.adh_oe));
        chk("adh_out_cd0", 16'(adh0), 16'(e.pc0[15:8]));
        chk("adh_out_cd1", 16'(adh1), 16'(e.pc1[15:8]));
      end
    end
  end

  initial begin
    strb_t s;
    n_RES = 1'b0; n_ready = 1'b0; n_1PC = 1'b1; PCL_PCL = 1'b1; ADL_PCL = 1'b0;
    n_ADL_PCL = 1'b1; PCH_PCH = 1'b1; n_PCH_PCH = 1'b0; ADH_PCH = 1'b0; DL_PCH = 1'b0;
    PC_DB = 1'b0; PCL_DB = 1'b0; PCH_DB = 1'b0; PCL_ADL = 1'b0; PCH_ADH = 1'b0;
    ADL = 8'h00; ADH = 8'h00; DL = 8'h00;
    m_pc0 = 16'h0000; m_pc1 = 16'h0000; m_cy1 = 0;

    repeat (4) step(strb_t'(14'($urandom)), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    step(ld(), 8'h34, 8'h12, 8'h00, 1'b0);
    repeat (3) step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);

    step(ld(), 8'hFF, 8'h12, 8'h00, 1'b0);
    step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);
    step(ld(), 8'hFF, 8'hFF, 8'h00, 1'b0);
    step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);

    step(ld(), 8'hFF, 8'h12, 8'h00, 1'b0);
    step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);
    s = inc(); s.n_ready = 1'b1;
    repeat (4) step(s, 8'h00, 8'h00, 8'h00, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);

    step(ld(), 8'hCD, 8'hAB, 8'h00, 1'b0);
    s = base(); s.pc_db = 1'b1; s.pch_db = 1'b1;
    step(s, 8'h00, 8'h00, 8'h00, 1'b0);
    s = base(); s.pcl_db = 1'b1;
    step(s, 8'h00, 8'h00, 8'h00, 1'b0);
    s = base(); s.pcl_adl = 1'b1; s.pch_adh = 1'b1;
    step(s, 8'h00, 8'h00, 8'h00, 1'b0);
    s = base(); s.pc_db = 1'b1; s.pcl_db = 1'b1; s.pch_db = 1'b1;
    step(s, 8'h00, 8'h00, 8'h00, 1'b0);

    s = base(); s.adl_pcl = 1'b1; s.pcl_pcl = 1'b0;
    step(s, 8'h55, 8'h00, 8'h00, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);
    s = base(); s.pch_pch = 1'b0; s.n_pch_pch = 1'b1; s.dl_pch = 1'b1; s.adh_pch = 1'b1;
    step(s, 8'h00, 8'h99, 8'h77, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);

    // Reset while a deferred carry is pending must lose it.
    step(ld(), 8'hFF, 8'h12, 8'h00, 1'b0);
    step(inc(), 8'h00, 8'h00, 8'h00, 1'b0);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b1);
    step(base(), 8'h00, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      s = strb_t'(14'($urandom));
      if ($urandom_range(0, 7) != 0) begin
        s.n_adl_pcl = ~s.adl_pcl;
        s.n_pch_pch = ~s.pch_pch;
        if (s.adl_pcl) s.pcl_pcl = 1'b0;
        if (s.dl_pch) begin s.adh_pch = 1'b0; s.pch_pch = 1'b0; s.n_pch_pch = 1'b1; end
        else if (s.adh_pch) begin s.pch_pch = 1'b0; s.n_pch_pch = 1'b1; end
      end
      s.n_ready = ($urandom_range(0, 3) == 0);
      s.n_1pc   = ($urandom_range(0, 1) == 0);
      step(s, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 39) == 0);
    end

    repeat (3) @(posedge PHI0);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
